// File: rtl/trig_pkg.sv
// Shared types for the external trigger scheduler: FSM state encoding
// and the trigger source codes reported on trig_source.
package trig_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      DEAD = 2'd2
   } sched_state_t;

   localparam logic [1:0] SRC_NONE  = 2'd0;
   localparam logic [1:0] SRC_COINC = 2'd1;
   localparam logic [1:0] SRC_SOFT  = 2'd2;
   localparam logic [1:0] SRC_ROLL  = 2'd3;

endpackage

// File: rtl/ext_trig_sched_if.sv
// Signal bundle between the coincidence/slow-control side and the trigger
// scheduler, plus the scheduler's FSM state for observation.
interface ext_trig_sched_if
   import trig_pkg::*;
#(
   parameter int CNT_W = 32
);
   // No valid/ready pairs here: every input is a level or single-cycle pulse
   // sampled on each clk_adc edge, and every output is a registered level.
   logic              coinc_req;
   logic              soft_req;
   logic              dorolling;
   logic              calib_window;
   logic [31:0]       randnum;
   logic [31:0]       prescale;
   logic              clr_counts;
   logic              ext_trig_out;
   logic              busy;
   logic [1:0]        trig_source;
   logic [CNT_W-1:0]  n_fired;
   logic [CNT_W-1:0]  n_prescaled;
   logic [CNT_W-1:0]  n_inhibited;
   sched_state_t      state_dbg;

   modport slave (
      input  coinc_req, soft_req, dorolling, calib_window, randnum, prescale, clr_counts,
      output ext_trig_out, busy, trig_source, n_fired, n_prescaled, n_inhibited, state_dbg
   );

   modport master (
      output coinc_req, soft_req, dorolling, calib_window, randnum, prescale, clr_counts,
      input  ext_trig_out, busy, trig_source, n_fired, n_prescaled, n_inhibited, state_dbg
   );

endinterface

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones; a clear wins over an increment.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (inc_i && !(&count_q)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/ext_trig_sched.sv
// External trigger scheduler: arbitrates coincidence, software and rolling
// requests, applies prescale and dead time, and keeps saturating statistics.
module ext_trig_sched
   import trig_pkg::*;
#(
   parameter int PULSE_TICKS = 4,
   parameter int DEAD_TICKS  = 20,
   parameter int ROLL_BIT    = 25,
   parameter int CNT_W       = 32
) (
   input  logic             clk_adc,
   input  logic             nrst,
   ext_trig_sched_if.slave  bus
);

   localparam int TICK_MAX = (PULSE_TICKS > DEAD_TICKS) ? PULSE_TICKS : DEAD_TICKS;
   localparam int TICK_W   = $clog2(TICK_MAX + 1);

   sched_state_t      state_q;
   logic [TICK_W-1:0] tick_q;
   logic [ROLL_BIT:0] roll_q;
   logic [31:0]       randnum_q;
   logic [31:0]       prescale_q;
   logic              coinc_q;
   logic              soft_pend_q;
   logic              roll_pend_q;
   logic              trig_q;
   logic              busy_q;
   logic [1:0]        src_q;

   logic              idle_ok;
   logic              pre_pass;
   logic              soft_want;
   logic [ROLL_BIT:0] roll_next;
   logic              roll_exp;
   logic              roll_req;
   logic              take_coinc;
   logic              take_soft;
   logic              take_roll;
   logic              fire_go;
   logic              reject;
   logic              inhibit_edge;
   logic [CNT_W-1:0]  n_fired;
   logic [CNT_W-1:0]  n_prescaled;
   logic [CNT_W-1:0]  n_inhibited;

   // The timer expires on the increment that would set ROLL_BIT, so it never
   // holds that bit and the expiry is visible in the same cycle.
   assign roll_next  = roll_q + 1'b1;
   assign roll_exp   = (state_q != FIRE) && roll_next[ROLL_BIT];
   assign roll_req   = roll_pend_q | (roll_exp & bus.dorolling);

   assign idle_ok    = (state_q == IDLE) && !bus.calib_window;
   assign pre_pass   = (randnum_q <= prescale_q);
   assign soft_want  = bus.soft_req | soft_pend_q;
   assign take_coinc = idle_ok & bus.coinc_req;
   assign take_soft  = idle_ok & ~bus.coinc_req & soft_want;
   assign take_roll  = idle_ok & ~bus.coinc_req & ~soft_want & roll_req;
   assign fire_go    = (take_coinc & pre_pass) | take_soft | take_roll;
   assign reject     = take_coinc & ~pre_pass;
   assign inhibit_edge = bus.coinc_req & ~coinc_q & bus.calib_window;

   always_ff @(posedge clk_adc or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         tick_q      <= '0;
         roll_q      <= '0;
         randnum_q   <= '0;
         prescale_q  <= '0;
         coinc_q     <= 1'b0;
         soft_pend_q <= 1'b0;
         roll_pend_q <= 1'b0;
         trig_q      <= 1'b0;
         busy_q      <= 1'b0;
         src_q       <= SRC_NONE;
      end else begin
         randnum_q  <= bus.randnum;
         prescale_q <= bus.prescale;
         coinc_q    <= bus.coinc_req;

         if (take_soft)          soft_pend_q <= 1'b0;
         else if (bus.soft_req)  soft_pend_q <= 1'b1;

         if (take_roll)                       roll_pend_q <= 1'b0;
         else if (roll_exp && bus.dorolling)  roll_pend_q <= 1'b1;

         if (fire_go)               roll_q <= '0;
         else if (state_q != FIRE)  roll_q <= roll_exp ? '0 : roll_next;

         case (state_q)
            IDLE: begin
               if (fire_go) begin
                  state_q <= FIRE;
                  tick_q  <= TICK_W'(PULSE_TICKS - 1);
                  trig_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  src_q   <= take_coinc ? SRC_COINC : (take_soft ? SRC_SOFT : SRC_ROLL);
               end else if (reject) begin
                  state_q <= DEAD;
                  tick_q  <= TICK_W'(DEAD_TICKS - 1);
                  busy_q  <= 1'b1;
               end
            end
            FIRE: begin
               if (tick_q == '0) begin
                  state_q <= DEAD;
                  tick_q  <= TICK_W'(DEAD_TICKS - 1);
                  trig_q  <= 1'b0;
               end else begin
                  tick_q <= tick_q - 1'b1;
               end
            end
            DEAD: begin
               if (tick_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  tick_q <= tick_q - 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               trig_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_fired (
      .clk(clk_adc), .rst_n(nrst), .inc_i(fire_go), .clr_i(bus.clr_counts), .count_o(n_fired)
   );
   sat_counter #(.WIDTH(CNT_W)) u_prescaled (
      .clk(clk_adc), .rst_n(nrst), .inc_i(reject), .clr_i(bus.clr_counts), .count_o(n_prescaled)
   );
   sat_counter #(.WIDTH(CNT_W)) u_inhibited (
      .clk(clk_adc), .rst_n(nrst), .inc_i(inhibit_edge), .clr_i(bus.clr_counts), .count_o(n_inhibited)
   );

   assign bus.ext_trig_out = trig_q;
   assign bus.busy         = busy_q;
   assign bus.trig_source  = src_q;
   assign bus.n_fired      = n_fired;
   assign bus.n_prescaled  = n_prescaled;
   assign bus.n_inhibited  = n_inhibited;
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_ext_trig_sched.sv
// Self-checking bench for ext_trig_sched with a short rolling period and
// 4-bit counters so rolling and saturation behaviour are reachable quickly.
module tb_ext_trig_sched;
   import trig_pkg::*;

   localparam int PULSE = 4;
   localparam int DEAD  = 20;
   localparam int RBIT  = 6;
   localparam int CW    = 4;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   int   cyc = 0;

   ext_trig_sched_if #(.CNT_W(CW)) bus ();

   ext_trig_sched #(
      .PULSE_TICKS(PULSE), .DEAD_TICKS(DEAD), .ROLL_BIT(RBIT), .CNT_W(CW)
   ) dut (
      .clk_adc(clk),
      .nrst(nrst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   logic [1:0] exp_q[$];
   int rise_cyc[$];
   int rises = 0;
   logic prev_trig = 1'b0;
   int hi_len = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_rises(input int target, input int bound);
      int k;
      k = 0;
      while (rises < target && k < bound) begin
         @(negedge clk);
         k++;
      end
      check("pulse_arrival", (rises >= target), 1);
   endtask

   function automatic int last_gap();
      return rise_cyc[rise_cyc.size()-1] - rise_cyc[rise_cyc.size()-2];
   endfunction

   // Pulse monitor: pops the expected source on every rising edge and checks width on fall.
   always @(negedge clk) begin
      if (!nrst) begin
         prev_trig = 1'b0;
         hi_len = 0;
      end else begin
         if (bus.ext_trig_out && !prev_trig) begin
            rises++;
            rise_cyc.push_back(cyc);
            hi_len = 1;
            if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
            else check("trig_source", {30'd0, bus.trig_source}, {30'd0, exp_q.pop_front()});
         end else if (bus.ext_trig_out) begin
            hi_len++;
         end else if (prev_trig) begin
            check("pulse_width", hi_len, PULSE);
         end
         prev_trig = bus.ext_trig_out;
      end
   end

   typedef struct {
      logic [31:0] randnum;
      logic [31:0] prescale;
      logic        exp_fire;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int busy_cnt, trig_cnt, r0, c0;

      vecs[0] = '{32'd5, 32'd0, 1'b0};
      vecs[1] = '{32'd0, 32'd0, 1'b1};
      vecs[2] = '{32'd7, 32'd7, 1'b1};
      vecs[3] = '{32'd8, 32'd7, 1'b0};
      vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
      vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
      vecs[6] = '{32'd0, 32'hFFFF_FFFF, 1'b1};
      for (int i = 7; i < 9; i++) begin
         vecs[i].randnum  = $urandom;
         vecs[i].prescale = $urandom;
         vecs[i].exp_fire = (vecs[i].randnum <= vecs[i].prescale);
      end

      bus.coinc_req = 0; bus.soft_req = 0; bus.dorolling = 0; bus.calib_window = 0;
      bus.randnum = 0; bus.prescale = 0; bus.clr_counts = 0;

      // Reset state
      tick(3);
      check("rst_trig", bus.ext_trig_out, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_src", bus.trig_source, 0);
      check("rst_state", bus.state_dbg, IDLE);
      check("rst_n_fired", bus.n_fired, 0);
      nrst = 1;
      tick(2);

      // Single-coincidence prescale vectors
      for (int i = 0; i < 9; i++) begin
         bus.randnum = vecs[i].randnum;
         bus.prescale = vecs[i].prescale;
         bus.clr_counts = 1;
         tick(1);
         bus.clr_counts = 0;
         bus.coinc_req = 1;
         if (vecs[i].exp_fire) exp_q.push_back(SRC_COINC);
         tick(1);
         bus.coinc_req = 0;
         busy_cnt = 0; trig_cnt = 0;
         for (int k = 0; k < 30; k++) begin
            busy_cnt += bus.busy;
            trig_cnt += bus.ext_trig_out;
            tick(1);
         end
         check($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].exp_fire ? PULSE + DEAD : DEAD);
         check($sformatf("v%0d_trig_cycles", i), trig_cnt, vecs[i].exp_fire ? PULSE : 0);
         check($sformatf("v%0d_n_fired", i), bus.n_fired, {31'd0, vecs[i].exp_fire});
         check($sformatf("v%0d_n_prescaled", i), bus.n_prescaled, {31'd0, ~vecs[i].exp_fire});
      end

      // Prescale pass with coinc held 100 cycles
      bus.prescale = 32'hFFFF_FFFF;
      bus.clr_counts = 1;
      tick(1);
      bus.clr_counts = 0;
      repeat (4) exp_q.push_back(SRC_COINC);
      r0 = rises;
      bus.coinc_req = 1;
      tick(100);
      bus.coinc_req = 0;
      tick(30);
      check("hold_n_fired", bus.n_fired, 4);
      check("hold_rises", rises - r0, 4);
      for (int k = 1; k < 4; k++)
         check("hold_period", rise_cyc[rise_cyc.size()-k] - rise_cyc[rise_cyc.size()-k-1], PULSE + DEAD + 1);

      // Clear overrides an increment in the same cycle
      bus.coinc_req = 1; bus.clr_counts = 1;
      exp_q.push_back(SRC_COINC);
      tick(1);
      bus.coinc_req = 0; bus.clr_counts = 0;
      tick(1);
      check("clr_over_inc", bus.n_fired, 0);
      tick(30);

      // Priority: coinc beats soft, soft goes pending, second soft dropped
      r0 = rises;
      exp_q.push_back(SRC_COINC);
      exp_q.push_back(SRC_SOFT);
      bus.coinc_req = 1; bus.soft_req = 1;
      tick(1);
      bus.coinc_req = 0; bus.soft_req = 0;
      tick(5);
      bus.soft_req = 1;
      tick(1);
      bus.soft_req = 0;
      tick(70);
      check("prio_rises", rises - r0, 2);
      check("prio_gap", last_gap(), PULSE + DEAD + 1);
      check("prio_n_fired", bus.n_fired, 2);

      // Rolling trigger
      r0 = rises;
      bus.dorolling = 1;
      exp_q.push_back(SRC_ROLL);
      wait_rises(r0 + 1, 200);
      exp_q.push_back(SRC_ROLL);
      wait_rises(r0 + 2, 200);
      bus.dorolling = 0;
      check("roll_period", last_gap(), (1 << RBIT) + PULSE);
      tick(200);
      check("roll_disabled", rises - r0, 2);

      // Calibration inhibit
      bus.clr_counts = 1;
      tick(1);
      bus.clr_counts = 0;
      r0 = rises;
      exp_q.push_back(SRC_COINC);
      bus.coinc_req = 1;
      tick(1);
      bus.coinc_req = 0;
      tick(1);
      bus.calib_window = 1;
      tick(1);
      bus.soft_req = 1;
      tick(1);
      bus.soft_req = 0;
      for (int k = 0; k < 3; k++) begin
         bus.coinc_req = 1;
         tick(1);
         bus.coinc_req = 0;
         tick(2);
      end
      tick(40);
      check("calib_rises", rises - r0, 1);
      check("calib_n_fired", bus.n_fired, 1);
      check("calib_n_inhibited", bus.n_inhibited, 3);
      exp_q.push_back(SRC_SOFT);
      bus.calib_window = 0;
      c0 = cyc;
      wait_rises(r0 + 2, 10);
      check("calib_soft_latency", rise_cyc[rise_cyc.size()-1] - c0, 1);
      tick(30);

      // Saturation and clear
      bus.clr_counts = 1;
      tick(1);
      bus.clr_counts = 0;
      repeat (20) exp_q.push_back(SRC_COINC);
      bus.coinc_req = 1;
      tick(500);
      bus.coinc_req = 0;
      tick(30);
      check("sat_n_fired", bus.n_fired, 15);
      bus.clr_counts = 1;
      tick(1);
      bus.clr_counts = 0;
      check("sat_cleared", bus.n_fired, 0);

      // Asynchronous reset mid-pulse
      exp_q.push_back(SRC_COINC);
      bus.coinc_req = 1;
      tick(1);
      bus.coinc_req = 0;
      tick(1);
      check("pre_rst_trig", bus.ext_trig_out, 1);
      #2;
      nrst = 0;
      #1;
      check("async_rst_trig", bus.ext_trig_out, 0);
      check("async_rst_busy", bus.busy, 0);
      check("async_rst_src", bus.trig_source, 0);
      check("async_rst_n_fired", bus.n_fired, 0);
      tick(2);
      nrst = 1;
      tick(2);

      check("exp_q_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
